// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clk_div_ctrl slice.
// FSM state encoding and key bit positions.
package clk_div_pkg;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_PEND = 1'b1
   } state_t;

   localparam int KEY_INC = 0;
   localparam int KEY_DEC = 1;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, active ratio and divided-clock outputs.
// A new ratio is adopted only at the end of a full period.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int P_DIV_W    = 8,
   parameter int P_DIV_INIT = 10
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [P_DIV_W-1:0] i_n_pend,
   output logic               o_clk_div,
   output logic               o_clk_en,
   output logic [P_DIV_W-1:0] o_div_ratio
);

   localparam logic [P_DIV_W-1:0] INIT = P_DIV_W'(P_DIV_INIT);

   state_t             state;
   logic [P_DIV_W-1:0] cnt;
   logic [P_DIV_W-1:0] n_act;
   logic [P_DIV_W:0]   hi;
   logic               last;

   // high phase is ceil(N/2), so odd ratios stay high one extra cycle
   assign hi   = ({1'b0, n_act} + {{P_DIV_W{1'b0}}, 1'b1}) >> 1;
   assign last = (cnt == n_act - 1'b1);

   // count the period, register outputs, swap ratio at the wrap
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_RUN;
         cnt       <= '0;
         n_act     <= INIT;
         o_clk_div <= 1'b0;
         o_clk_en  <= 1'b0;
      end else begin
         o_clk_div <= ({1'b0, cnt} < hi);
         o_clk_en  <= (cnt == '0);
         cnt       <= last ? '0 : cnt + 1'b1;
         unique case (state)
            S_RUN: begin
               if (i_n_pend != n_act)
                  state <= S_PEND;
            end
            S_PEND: begin
               if (last) begin
                  n_act <= i_n_pend;
                  state <= S_RUN;
               end
            end
         endcase
      end
   end

   assign o_div_ratio = n_act;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: key presses -> saturating ratio -> glitch-free divided clock.
// Optional ack LED timer enabled by defining CLK_DIV_CTRL_ACK_EN.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int P_SYSTEM_CLK = 100_000_000,
   parameter int P_DIV_W      = 8,
   parameter int P_DIV_MIN    = 2,
   parameter int P_DIV_MAX    = 255,
   parameter int P_DIV_INIT   = 10,
   parameter int P_KEY_ACT    = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_key_val,
   input  logic [1:0]         i_key,
   output logic               o_clk_div,
   output logic               o_clk_en,
   output logic [P_DIV_W-1:0] o_div_ratio,
   output logic               o_ack_led
);

   localparam logic KA = 1'(P_KEY_ACT);
   localparam logic [P_DIV_W-1:0] INIT  = P_DIV_W'(P_DIV_INIT);
   localparam logic [P_DIV_W:0]   MIN_X = (P_DIV_W+1)'(P_DIV_MIN);
   localparam logic [P_DIV_W:0]   MAX_X = (P_DIV_W+1)'(P_DIV_MAX);

   logic [1:0]         r_key_prev;
   logic [1:0]         press;
   logic [P_DIV_W-1:0] n_pend;
   logic [P_DIV_W-1:0] n_next;
   logic [P_DIV_W:0]   pend_x;

   assign press[KEY_INC] = i_key_val
                         && (i_key[KEY_INC] == KA)
                         && (r_key_prev[KEY_INC] != KA);
   assign press[KEY_DEC] = i_key_val
                         && (i_key[KEY_DEC] == KA)
                         && (r_key_prev[KEY_DEC] != KA);
   assign pend_x = {1'b0, n_pend};

   // next pending ratio; saturated presses leave it untouched
   always_comb begin
      n_next = n_pend;
      unique case (1'b1)
         press[KEY_INC] && press[KEY_DEC]:
            n_next = INIT;
         press[KEY_INC] && !press[KEY_DEC]:
            if (pend_x < MAX_X)
               n_next = n_pend + 1'b1;
         press[KEY_DEC] && !press[KEY_INC]:
            if (pend_x > MIN_X)
               n_next = n_pend - 1'b1;
         default: ;
      endcase
   end

   // remember last key level and hold the requested ratio
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_key_prev <= ~{2{KA}};
         n_pend     <= INIT;
      end else begin
         if (i_key_val)
            r_key_prev <= i_key;
         n_pend <= n_next;
      end
   end

   clk_div_core #(
      .P_DIV_W    (P_DIV_W),
      .P_DIV_INIT (P_DIV_INIT)
   ) u_core (
      .clk         (clk),
      .rstn        (rstn),
      .i_n_pend    (n_pend),
      .o_clk_div   (o_clk_div),
      .o_clk_en    (o_clk_en),
      .o_div_ratio (o_div_ratio)
   );

`ifdef CLK_DIV_CTRL_ACK_EN
   localparam int ACK_CYC = P_SYSTEM_CLK / 10;
   localparam int ACK_W   = $clog2(ACK_CYC + 1);

   logic             accept;
   logic [ACK_W-1:0] ack_cnt;

   assign accept = (n_next != n_pend);

   // 100 ms LED stretch, restarted by every accepted change
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ack_cnt <= '0;
      else if (accept)
         ack_cnt <= ACK_W'(ACK_CYC);
      else if (ack_cnt != '0)
         ack_cnt <= ack_cnt - 1'b1;
   end

   assign o_ack_led = (ack_cnt != '0);
`else
   assign o_ack_led = 1'b0;
`endif

endmodule
